tiny_soc_core: RTL and testbench
================================

// Module: tiny_soc_core
// PURPOSE
//  Parametrised successor of the TinyTapeout tiny SoC core. After reset it serially loads IMEM_DEPTH instructions in CHUNK_W-bit pieces.
//  It then runs them one per cycle on a NUM_REGS x DATA_W register file. Adds OUT, BZ and HALT, plus load/run status outputs.
//  Sits under the chip wrapper: io_in[0]=clk, io_in[1]=rst, io_in[7:2]=load_chunk, io_out=out_data.
// PARAMETERS
//  CHUNK_W     6   load chunk width (bits per clock)
//  DATA_W      4   register/ALU width
//  NUM_REGS    4   register count, power of 2, >=2; RI=clog2(NUM_REGS)
//  IMEM_DEPTH  16  instruction count, power of 2; PCW=clog2(IMEM_DEPTH)
//  OUT_W       8   out_data width, must be >= DATA_W
//  derived: INSTR_W=6+3*RI (12 default); NCHUNK=ceil(INSTR_W/CHUNK_W); require DATA_W<=INSTR_W-3-RI
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        synchronous, active-high reset
//  load_chunk  in   CHUNK_W  instruction chunk, sampled every clk while loading
//  out_data    out  OUT_W    last OUT value, zero-extended
//  pc          out  PCW      current program counter
//  loading     out  1        1 = LOAD phase
//  halted      out  1        1 = HALT executed
// BEHAVIOUR
//  Reset (on clk edge with rst=1): loading=1, halted=0, pc=0, out_data=0, all regs=0, chunk cnt=0, wr_ptr=0; imem not cleared.
//  LOAD: each clk latches load_chunk, LSB chunk first. On the NCHUNK-th chunk, imem[wr_ptr]<=assembled word and wr_ptr++.
//   - Surplus top bits of the last chunk are ignored.
//   - On the write of imem[IMEM_DEPTH-1], loading goes 0 on that same edge and pc=0.
//   - Load time = NCHUNK*IMEM_DEPTH cycles (32 default). No instruction executes while loading=1.
//  RUN: instr=imem[pc], read combinationally; one instruction per cycle.
//   - Reg/out/pc updates occur on the edge that ends the cycle. Default next pc = pc+1, wrapping IMEM_DEPTH-1 -> 0.
//  Format, MSB down: op[3] | rd[RI] | rs1[RI] | rs2[RI] | func[3]; imm = instr[DATA_W-1:0].
//  Opcodes:
//   000 ALU   rd<=f(rs1,rs2): 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 rs1<<1, 6 rs1>>1, 7 rs1; all mod 2^DATA_W
//   001 OUT   out_data<=zext(rs1)
//   010 BZ    if rs1==0: pc<=rs2 value
//   011 IMM   rd<=imm
//   100 JUMP  pc<=rs2 value
//   101/111 NOP
//   110 HALT  halted<=1
//  Jump/branch target: register value zero-extended or truncated to PCW bits.
//  Reads see pre-edge register values; rd==rs gives the old operand.
//  halted=1: pc, regs and out_data frozen until rst.
//  rst mid-LOAD: partial chunk/word discarded, reload from imem[0]. rst in RUN/HALT: back to LOAD.
// STRUCTURE
//  tiny_soc_pkg: opcode and ALU func localparams, field-position helpers; shared with testbench and assembler script.
//  Sub-module tiny_soc_loader: chunk counter, shift/assemble register, wr_ptr, imem write enable, loading flag.
//  Core contains imem array, regfile, ALU and pc logic.
// TESTING (defaults)
//  1 Load IMM r3=4; IMM r2=1; ADD r3=r3+r2; OUT r3; JUMP r2; rest NOP
//    -> loading falls 32 cycles after reset; out_data = 5,6,7... one step per 4-cycle loop, wraps 15->0.
//  2 Program with HALT at imem[2]
//    -> halted=1 after 3 run cycles, pc stuck at 2; state held for 20 cycles.
//  3 IMM r1=0; BZ r1->r2 (r2=9 via IMM); then IMM r1=1 and BZ again
//    -> pc=9 on first BZ, pc increments on second.
//  4 All 16 words NOP
//    -> pc counts 0..15 then wraps to 0; out_data stays 0.
//  5 Assert rst after 7 chunks
//    -> loading stays 1 and the next 32 chunks load imem[0..15]. The earlier partial word has no effect.
//  6 ALU func sweep with r1=0xC, r2=0x6
//    -> add=0x2, sub=0x6, and=0x4, or=0xE, xor=0xA, shl=0x8, shr=0x6, pass=0xC.

Source files
------------

// File: rtl/tiny_soc_pkg.sv
// rtl/tiny_soc_pkg.sv - shared opcodes, ALU functions and instruction field helpers
// Purpose : constants shared by the core, the loader, the testbench and the assembler.
// Ports   : none (package).
package tiny_soc_pkg;

   // Opcodes (instruction bits [MSB -: 3])
   localparam logic [2:0] OP_ALU  = 3'b000;
   localparam logic [2:0] OP_OUT  = 3'b001;
   localparam logic [2:0] OP_BZ   = 3'b010;
   localparam logic [2:0] OP_IMM  = 3'b011;
   localparam logic [2:0] OP_JUMP = 3'b100;
   localparam logic [2:0] OP_NOP  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_NOP2 = 3'b111;

   // ALU functions (instruction bits [2:0])
   localparam logic [2:0] FN_ADD  = 3'd0;
   localparam logic [2:0] FN_SUB  = 3'd1;
   localparam logic [2:0] FN_AND  = 3'd2;
   localparam logic [2:0] FN_OR   = 3'd3;
   localparam logic [2:0] FN_XOR  = 3'd4;
   localparam logic [2:0] FN_SHL  = 3'd5;
   localparam logic [2:0] FN_SHR  = 3'd6;
   localparam logic [2:0] FN_PASS = 3'd7;

   localparam int FUNC_W  = 3;
   localparam int RS2_LSB = FUNC_W;

   // Layout: op[3] | rd[ri] | rs1[ri] | rs2[ri] | func[3]
   function automatic int instr_width(input int ri);
      return 6 + 3 * ri;
   endfunction

   function automatic int rs1_lsb(input int ri);
      return FUNC_W + ri;
   endfunction

   function automatic int rd_lsb(input int ri);
      return FUNC_W + 2 * ri;
   endfunction

   function automatic int op_lsb(input int ri);
      return FUNC_W + 3 * ri;
   endfunction

   function automatic int num_chunks(input int instr_w, input int chunk_w);
      return (instr_w + chunk_w - 1) / chunk_w;
   endfunction

endpackage

// File: rtl/tiny_soc_loader.sv
// rtl/tiny_soc_loader.sv - serial instruction loader for the tiny SoC core
// Purpose : assembles CHUNK_W-bit pieces (LSB chunk first) into instruction words and
//           writes them to imem[0..IMEM_DEPTH-1]; drops the loading flag after the last word.
// Ports   : clk, rst (sync, active-high), load_chunk (chunk input),
//           loading (1 while loading), wr_en/wr_addr/wr_data (imem write port).
module tiny_soc_loader
   import tiny_soc_pkg::*;
#(
   parameter int CHUNK_W    = 6,
   parameter int INSTR_W    = 12,
   parameter int IMEM_DEPTH = 16,
   parameter int PCW        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CHUNK_W-1:0] load_chunk,
   output logic               loading,
   output logic               wr_en,
   output logic [PCW-1:0]     wr_addr,
   output logic [INSTR_W-1:0] wr_data
);

   localparam int NCHUNK = num_chunks(INSTR_W, CHUNK_W);
   localparam int TOT_W  = NCHUNK * CHUNK_W;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   logic [TOT_W-1:0] r_shift;
   logic [TOT_W-1:0] w_shift_next;
   logic [CW-1:0]    r_cnt;
   logic [PCW-1:0]   r_wr_ptr;
   logic             r_loading;
   logic             w_last;

   // New chunk enters at the top; after NCHUNK chunks the first one sits at bit 0.
   // Surplus top bits of the final chunk fall outside INSTR_W and are dropped.
   assign w_shift_next = (r_shift >> CHUNK_W) | (TOT_W'(load_chunk) << (TOT_W - CHUNK_W));
   assign w_last       = (r_cnt == CW'(NCHUNK - 1));

   assign loading = r_loading;
   assign wr_en   = r_loading && w_last;
   assign wr_addr = r_wr_ptr;
   assign wr_data = w_shift_next[INSTR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_cnt     <= '0;
         r_wr_ptr  <= '0;
         r_loading <= 1'b1;
      end else if (r_loading) begin
         r_shift <= w_shift_next;
         if (w_last) begin
            r_cnt    <= '0;
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_wr_ptr == PCW'(IMEM_DEPTH - 1))
               r_loading <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tiny_soc_core.sv
// rtl/tiny_soc_core.sv - tiny SoC core: serial program load then one instruction per cycle
// Purpose : holds imem, register file, ALU and pc; executes loaded program after load.
// Ports   : clk, rst (sync, active-high), load_chunk (serial program input),
//           out_data (last OUT value, zero-extended), pc (program counter),
//           loading (1 during load phase), halted (1 after HALT).
module tiny_soc_core
   import tiny_soc_pkg::*;
#(
   parameter int  CHUNK_W    = 6,
   parameter int  DATA_W     = 4,
   parameter int  NUM_REGS   = 4,
   parameter int  IMEM_DEPTH = 16,
   parameter int  OUT_W      = 8,
   localparam int PCW        = $clog2(IMEM_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CHUNK_W-1:0] load_chunk,
   output logic [OUT_W-1:0]   out_data,
   output logic [PCW-1:0]     pc,
   output logic               loading,
   output logic               halted
);

   localparam int RI      = $clog2(NUM_REGS);
   localparam int INSTR_W = instr_width(RI);
   localparam int OP_L    = op_lsb(RI);
   localparam int RD_L    = rd_lsb(RI);
   localparam int RS1_L   = rs1_lsb(RI);

   logic [INSTR_W-1:0] r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]  r_regs [NUM_REGS];
   logic [PCW-1:0]     r_pc;
   logic [OUT_W-1:0]   r_out;
   logic               r_halted;

   logic               w_loading;
   logic               w_wr_en;
   logic [PCW-1:0]     w_wr_addr;
   logic [INSTR_W-1:0] w_wr_data;

   logic [INSTR_W-1:0] w_instr;
   logic [2:0]         w_op;
   logic [RI-1:0]      w_rd;
   logic [RI-1:0]      w_rs1;
   logic [RI-1:0]      w_rs2;
   logic [2:0]         w_func;
   logic [DATA_W-1:0]  w_imm;
   logic [DATA_W-1:0]  w_a;
   logic [DATA_W-1:0]  w_b;
   logic [DATA_W-1:0]  w_alu;
   logic [PCW-1:0]     w_tgt;

   tiny_soc_loader #(
      .CHUNK_W    (CHUNK_W),
      .INSTR_W    (INSTR_W),
      .IMEM_DEPTH (IMEM_DEPTH),
      .PCW        (PCW)
   ) u_loader (
      .clk        (clk),
      .rst        (rst),
      .load_chunk (load_chunk),
      .loading    (w_loading),
      .wr_en      (w_wr_en),
      .wr_addr    (w_wr_addr),
      .wr_data    (w_wr_data)
   );

   // Program memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_imem[w_wr_addr] <= w_wr_data;
   end

   assign w_instr = r_imem[r_pc];
   assign w_op    = w_instr[OP_L +: 3];
   assign w_rd    = w_instr[RD_L +: RI];
   assign w_rs1   = w_instr[RS1_L +: RI];
   assign w_rs2   = w_instr[RS2_LSB +: RI];
   assign w_func  = w_instr[FUNC_W-1:0];
   assign w_imm   = w_instr[DATA_W-1:0];   // overlaps rs2/func by design
   assign w_a     = r_regs[w_rs1];
   assign w_b     = r_regs[w_rs2];
   assign w_tgt   = PCW'(w_b);             // zero-extend or truncate to pc width

   always_comb begin
      w_alu = w_a;
      case (w_func)
         FN_ADD:  w_alu = w_a + w_b;
         FN_SUB:  w_alu = w_a - w_b;
         FN_AND:  w_alu = w_a & w_b;
         FN_OR:   w_alu = w_a | w_b;
         FN_XOR:  w_alu = w_a ^ w_b;
         FN_SHL:  w_alu = w_a << 1;
         FN_SHR:  w_alu = w_a >> 1;
         FN_PASS: w_alu = w_a;
         default: w_alu = w_a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= '0;
         r_out    <= '0;
         r_halted <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (w_loading) begin
         r_pc <= '0;
      end else if (!r_halted) begin
         r_pc <= r_pc + 1'b1;
         case (w_op)
            OP_ALU:  r_regs[w_rd] <= w_alu;
            OP_OUT:  r_out <= OUT_W'(w_a);
            OP_BZ:   if (w_a == '0) r_pc <= w_tgt;
            OP_IMM:  r_regs[w_rd] <= w_imm;
            OP_JUMP: r_pc <= w_tgt;
            OP_HALT: begin
               r_halted <= 1'b1;
               r_pc     <= r_pc;   // pc stays on the HALT instruction
            end
            OP_NOP, OP_NOP2: ;
            default: ;
         endcase
      end
   end

   assign out_data = r_out;
   assign pc       = r_pc;
   assign loading  = w_loading;
   assign halted   = r_halted;

endmodule

// File: tb/tb_tiny_soc_core.sv
// tb/tb_tiny_soc_core.sv - directed self-checking bench for tiny_soc_core
module tb_tiny_soc_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] load_chunk = '0;
   logic [7:0] out_data;
   logic [3:0] pc;
   logic       loading;
   logic       halted;

   int n_checks = 0;
   int n_fail   = 0;

   logic [11:0] prog [16];

   localparam logic [11:0] NOP  = 12'hA00;
   localparam logic [11:0] HALT = 12'hC00;

   tiny_soc_core dut (
      .clk        (clk),
      .rst        (rst),
      .load_chunk (load_chunk),
      .out_data   (out_data),
      .pc         (pc),
      .loading    (loading),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [2:0] fn);
      return {op, rd, rs1, rs2, fn};
   endfunction

   function automatic logic [11:0] enc_imm(input logic [1:0] rd, input logic [3:0] imm);
      return {3'b011, rd, 2'b00, 1'b0, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      load_chunk = '0;
      step();
      rst = 1'b0;
      check({tag, "_rst_loading"}, 32'(loading), 32'd1);
      check({tag, "_rst_halted"}, 32'(halted), 32'd0);
      check({tag, "_rst_pc"}, 32'(pc), 32'd0);
      check({tag, "_rst_out"}, 32'(out_data), 32'd0);
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 16; i++) prog[i] = NOP;
   endtask

   task automatic load(input string tag);
      for (int w = 0; w < 16; w++) begin
         for (int c = 0; c < 2; c++) begin
            load_chunk = (c == 0) ? prog[w][5:0] : prog[w][11:6];
            if (w == 15 && c == 1) check({tag, "_load_busy"}, 32'(loading), 32'd1);
            step();
         end
      end
      load_chunk = '0;
      check({tag, "_load_done"}, 32'(loading), 32'd0);
      check({tag, "_load_pc"}, 32'(pc), 32'd0);
   endtask

   task automatic alu_sweep(input int base);
      logic [3:0] exp_v [8];
      exp_v = '{4'h2, 4'h6, 4'h4, 4'hE, 4'hA, 4'h8, 4'h6, 4'hC};
      fill_nop();
      prog[0] = enc_imm(2'd1, 4'hC);
      prog[1] = enc_imm(2'd2, 4'h6);
      for (int k = 0; k < 4; k++) begin
         prog[2 + 2*k] = enc(3'b000, 2'd3, 2'd1, 2'd2, 3'(base + k));
         prog[3 + 2*k] = enc(3'b001, 2'd0, 2'd3, 2'd0, 3'd0);
      end
      prog[10] = HALT;
      do_reset($sformatf("t6_%0d", base));
      load($sformatf("t6_%0d", base));
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         step();
         check($sformatf("t6_alu_fn%0d", base + k), 32'(out_data), 32'(exp_v[base + k]));
      end
   endtask

   initial begin
      // 1: counting loop through ADD/OUT/JUMP
      fill_nop();
      prog[0] = enc_imm(2'd3, 4'd4);
      prog[1] = enc_imm(2'd2, 4'd1);
      prog[2] = enc(3'b000, 2'd3, 2'd3, 2'd2, 3'd0);
      prog[3] = enc(3'b001, 2'd0, 2'd3, 2'd0, 3'd0);
      prog[4] = enc(3'b100, 2'd0, 2'd0, 2'd2, 3'd0);
      do_reset("t1");
      load("t1");
      repeat (3) step();
      check("t1_out_pre", 32'(out_data), 32'd0);
      step();
      check("t1_out_first", 32'(out_data), 32'd5);
      check("t1_pc_first", 32'(pc), 32'd4);
      for (int i = 1; i <= 11; i++) begin
         repeat (4) step();
         check($sformatf("t1_out_%0d", i), 32'(out_data), 32'((5 + i) % 16));
      end

      // 2: HALT freezes state
      fill_nop();
      prog[2] = HALT;
      prog[3] = enc_imm(2'd1, 4'd7);
      prog[4] = enc(3'b001, 2'd0, 2'd1, 2'd0, 3'd0);
      do_reset("t2");
      load("t2");
      step();
      step();
      check("t2_halted_pre", 32'(halted), 32'd0);
      check("t2_pc_pre", 32'(pc), 32'd2);
      step();
      check("t2_halted", 32'(halted), 32'd1);
      check("t2_pc_halt", 32'(pc), 32'd2);
      repeat (20) step();
      check("t2_halted_hold", 32'(halted), 32'd1);
      check("t2_pc_hold", 32'(pc), 32'd2);
      check("t2_out_hold", 32'(out_data), 32'd0);

      // 3: BZ taken then not taken
      fill_nop();
      prog[0]  = enc_imm(2'd2, 4'd9);
      prog[1]  = enc_imm(2'd1, 4'd0);
      prog[2]  = enc(3'b010, 2'd0, 2'd1, 2'd2, 3'd0);
      prog[9]  = enc_imm(2'd1, 4'd1);
      prog[10] = enc(3'b010, 2'd0, 2'd1, 2'd2, 3'd0);
      do_reset("t3");
      load("t3");
      repeat (3) step();
      check("t3_bz_taken", 32'(pc), 32'd9);
      step();
      check("t3_pc_after_imm", 32'(pc), 32'd10);
      step();
      check("t3_bz_not_taken", 32'(pc), 32'd11);

      // 4: all NOP, pc wraps
      fill_nop();
      do_reset("t4");
      load("t4");
      for (int k = 1; k <= 17; k++) begin
         step();
         check($sformatf("t4_pc_%0d", k), 32'(pc), 32'(k % 16));
      end
      check("t4_out", 32'(out_data), 32'd0);

      // 5: reset after a partial load
      do_reset("t5");
      for (int k = 0; k < 7; k++) begin
         load_chunk = 6'(6'h15 + k);
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_loading_after_rst", 32'(loading), 32'd1);
      check("t5_pc_after_rst", 32'(pc), 32'd0);
      fill_nop();
      prog[0] = enc_imm(2'd1, 4'hA);
      prog[1] = enc(3'b001, 2'd0, 2'd1, 2'd0, 3'd0);
      load("t5");
      step();
      step();
      check("t5_out", 32'(out_data), 32'h0A);
      check("t5_pc", 32'(pc), 32'd2);

      // 6: ALU function sweep, r1=0xC r2=0x6
      alu_sweep(0);
      alu_sweep(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
